// File: rtl/clk_en_nco.sv
// clk_en_nco: N-channel fractional clock-enable NCO bank gated by a PLL-lock sequencer.
// Optional CLKEN_PAUSE_EN macro builds a pause that freezes all accumulators while running.
module clk_en_nco #(
    parameter int NUM_CH      = 6,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter int LOCK_CNT_W  = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              pause,
    output logic [NUM_CH-1:0] ce_out,
    output logic              ready
);
    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t                state_q;
    logic                  sync1_q, sync2_q;
    logic                  ready_q, cfg_ready_q;
    logic [LOCK_CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0]     ce_q;
    logic [ACC_W-1:0]      inc_q   [NUM_CH];
    logic [ACC_W-1:0]      phase_q [NUM_CH];
    logic [ACC_W-1:0]      acc_q   [NUM_CH];
    logic [ACC_W:0]        sum_d   [NUM_CH];
    logic                  cfg_acc;
    logic                  hold;

`ifdef CLKEN_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold = 1'b0;
`endif

    assign cfg_acc   = cfg_valid && cfg_ready_q;
    assign cfg_ready = cfg_ready_q;
    assign ce_out    = ce_q;
    assign ready     = ready_q;

    // Top bit of each sum is the carry that becomes the enable pulse.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) sum_d[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            ready_q     <= 1'b0;
            cfg_ready_q <= 1'b0;
            cnt_q       <= '0;
            ce_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                inc_q[i]   <= '0;
                phase_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= pll_locked;
            sync2_q     <= sync1_q;
            cfg_ready_q <= !cfg_acc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_acc && cfg_ch == CH_W'(i)) begin
                    inc_q[i]   <= cfg_inc;
                    phase_q[i] <= cfg_phase;
                end
            end
            if (state_q == WAIT_LOCK) begin
                ce_q <= '0;
                for (int i = 0; i < NUM_CH; i++) acc_q[i] <= phase_q[i];
                if (!sync2_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == LOCK_CNT_W'(LOCK_CYCLES - 1)) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + LOCK_CNT_W'(1);
                end
            end else if (!sync2_q) begin
                state_q <= WAIT_LOCK;
                ready_q <= 1'b0;
                ce_q    <= '0;
                for (int i = 0; i < NUM_CH; i++) acc_q[i] <= phase_q[i];
            end else if (hold) begin
                ce_q <= '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= sum_d[i][ACC_W-1:0];
                    ce_q[i]  <= sum_d[i][ACC_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_en_nco.sv
// tb_clk_en_nco: randomized and directed checks of clk_en_nco against an arithmetic reference model.
module tb_clk_en_nco;
    localparam int NUM_CH = 6;
    localparam int ACC_W  = 32;
    localparam int LOCK   = 16;

    logic              clk = 0;
    logic              rst_n;
    logic              pll_locked;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              pause;
    logic [NUM_CH-1:0] ce_out;
    logic              ready;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    clk_en_nco #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK), .LOCK_CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .pause(pause), .ce_out(ce_out), .ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: lock is a streak of delayed lock samples, each channel a 64-bit position.
    bit                lhist[$];
    longint            streak;
    bit                ready_m, crdy_m;
    logic [NUM_CH-1:0] ce_m;
    logic [63:0]       pos [NUM_CH];
    logic [63:0]       inc_m [NUM_CH];
    logic [63:0]       ph_m [NUM_CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhist = '{0, 0};
            streak = 0;
            ready_m = 0;
            crdy_m = 0;
            ce_m = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos[i] = 0; inc_m[i] = 0; ph_m[i] = 0;
            end
        end else begin
            bit acc_now, ls, was, paused;
            logic [63:0] s;
            acc_now = cfg_valid && crdy_m;
            ls = lhist.pop_front();
            lhist.push_back(pll_locked);
            was = ready_m;
            streak = ls ? streak + 1 : 0;
            ready_m = streak >= LOCK;
`ifdef CLKEN_PAUSE_EN
            paused = pause;
`else
            paused = 0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (ready_m && !was) begin
                    pos[i] = ph_m[i];
                    ce_m[i] = 0;
                end else if (ready_m && !paused) begin
                    s = pos[i] + inc_m[i];
                    ce_m[i] = s >= 64'h1_0000_0000;
                    pos[i] = s % 64'h1_0000_0000;
                end else begin
                    ce_m[i] = 0;
                end
            end
            if (acc_now && cfg_ch < NUM_CH) begin
                inc_m[cfg_ch] = {32'd0, cfg_inc};
                ph_m[cfg_ch] = {32'd0, cfg_phase};
            end
            crdy_m = !acc_now;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            total++;
            if (ce_out !== ce_m || ready !== ready_m || cfg_ready !== crdy_m) begin
                bad++;
                $display("FAIL model t=%0t ce_out=%b exp=%b ready=%b exp=%b cfg_ready=%b exp=%b",
                         $time, ce_out, ce_m, ready, ready_m, cfg_ready, crdy_m);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] inc, input logic [31:0] ph);
        int n = 0;
        while (!cfg_ready && n < 10) begin @(negedge clk); n++; end
        chk("cfg_ready_wait", cfg_ready, 1);
        cfg_valid = 1; cfg_ch = 3'(ch); cfg_inc = inc; cfg_phase = ph;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
    endtask

    initial begin
        int n, r0, r1, r2, last2, gap_ok, p0, p1;
        int first[NUM_CH], c1k[NUM_CH], c3k[NUM_CH];
        rst_n = 0; pll_locked = 0; cfg_valid = 0; cfg_ch = 0; cfg_inc = 0; cfg_phase = 0; pause = 0;
        #3;
        chk("rst_ready", ready, 0);
        chk("rst_ce_out", ce_out, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1; chk_en = 1;
        @(negedge clk);
        chk("cfg_ready_after_rst", cfg_ready, 1);
        cfg_valid = 1; cfg_ch = 0; cfg_inc = 32'h4000_0000; cfg_phase = 0;
        r0 = cfg_ready; @(negedge clk);
        r1 = cfg_ready; @(negedge clk);
        r2 = cfg_ready; cfg_valid = 0;
        chk("b2b_ready0", r0, 1);
        chk("b2b_ready1", r1, 0);
        chk("b2b_ready2", r2, 1);
        cfg(1, 32'h4000_0000, 32'h8000_0000);
        cfg(2, 32'h5555_5555, 0);
        cfg(3, 32'h8000_0000, 0);
        cfg(4, 0, 0);
        cfg(5, 32'hFFFF_FFFF, 0);
        cfg(6, 32'h1234_5678, 32'h9ABC_DEF0);
        cfg(7, 32'h1111_1111, 32'h2222_2222);

        pll_locked = 1;
        repeat (LOCK - 1) @(negedge clk);
        chk("no_early_ready", ready, 0);
        pll_locked = 0; @(negedge clk); pll_locked = 1;
        wait_ready(n);
        chk("lock_latency_glitch", n, LOCK + 2);

        for (int i = 0; i < NUM_CH; i++) begin first[i] = 0; c1k[i] = 0; c3k[i] = 0; end
        last2 = 0; gap_ok = 1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ce_out[i]) begin
                    if (first[i] == 0) first[i] = c;
                    c3k[i]++;
                    if (c <= 1000) c1k[i]++;
                end
            end
            if (ce_out[2]) begin
                if (last2 != 0 && (c - last2) != 2 && (c - last2) != 3) gap_ok = 0;
                last2 = c;
            end
        end
        chk("ch0_first_pulse", first[0], 4);
        chk("ch1_first_pulse", first[1], 2);
        chk("ch0_count_1000", c1k[0], 250);
        chk("ch1_count_1000", c1k[1], 250);
        chk("ch3_half_rate_1000", c1k[3], 500);
        chk("ch2_frac_count_ok", (c3k[2] == 999 || c3k[2] == 1000), 1);
        chk("ch2_gaps_ok", gap_ok, 1);
        chk("ch4_silent", c3k[4], 0);
        chk("ch5_max_inc", c3k[5], 2999);

        cfg(6, $urandom, $urandom);
        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            p0 += int'(ce_out[0]); p1 += int'(ce_out[5]);
        end
        chk("oob_cfg_ch0_rate", p0, 100);
        chk("oob_cfg_ch5_rate", p1, 400);

`ifdef CLKEN_PAUSE_EN
        n = 0;
        while (!ce_out[0] && n < 10) begin @(negedge clk); n++; end
        chk("pause_sync_pulse", ce_out[0], 1);
        pause = 1;
        repeat (7) @(negedge clk);
        pause = 0;
        n = 7;
        while (!ce_out[0] && n < 40) begin @(negedge clk); n++; end
        chk("pause_shift", n, 11);
`endif

        pll_locked = 0;
        repeat (3) @(negedge clk);
        chk("lossy_ready", ready, 0);
        chk("lossy_ce_out", ce_out, 0);
        repeat (4) @(negedge clk);
        pll_locked = 1;
        wait_ready(n);
        chk("relock_latency", n, LOCK + 2);
        first[0] = 0; first[1] = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ce_out[0] && first[0] == 0) first[0] = c;
            if (ce_out[1] && first[1] == 0) first[1] = c;
        end
        chk("relock_ch0_first", first[0], 4);
        chk("relock_ch1_first", first[1], 2);

        for (int c = 0; c < 3000; c++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_inc = $urandom;
            cfg_phase = $urandom;
            if ($urandom_range(0, 199) == 0) pll_locked = !pll_locked;
            pause = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        cfg_valid = 0; pause = 0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
